// File: rtl/mul_share_pkg.sv
// Shared constants, helpers and the shadow-pipeline entry type for the
// shared multiplier scheduler.
package mul_share_pkg;

  localparam int unsigned DefAWidth     = 14;
  localparam int unsigned DefBWidth     = 28;
  localparam int unsigned DefPWidth     = 32;
  localparam int unsigned DefMulLatency = 3;
  // Wide enough for the largest supported requester count (16).
  localparam int unsigned MaxIdWidth    = 4;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  typedef struct packed {
    logic                  valid;
    logic [MaxIdWidth-1:0] id;
  } shadow_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above rr_ptr,
// wrapping around. The pointer itself is owned by the caller.
module rr_arbiter
  import mul_share_pkg::*;
#(
  parameter int unsigned  NUM_REQ  = 4,
  localparam int unsigned ID_WIDTH = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic                grant_valid,
  output logic [ID_WIDTH-1:0] grant_id
);

  int unsigned idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (32'(rr_ptr) + off) % NUM_REQ;
      if (!grant_valid && req[ID_WIDTH'(idx)]) begin
        grant_valid = 1'b1;
        grant_id    = ID_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/mul_share_scheduler.sv
// Time-shares one external pipelined multiplier between NUM_REQ requesters and
// returns each product tagged with its requester id, in accept order.
module mul_share_scheduler
  import mul_share_pkg::*;
#(
  parameter int unsigned  NUM_REQ     = 4,
  parameter int unsigned  A_WIDTH     = DefAWidth,
  parameter int unsigned  B_WIDTH     = DefBWidth,
  parameter int unsigned  P_WIDTH     = DefPWidth,
  parameter int unsigned  MUL_LATENCY = DefMulLatency,
  localparam int unsigned ID_WIDTH    = clog2(NUM_REQ)
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [P_WIDTH-1:0]         rsp_p,
  output logic [ID_WIDTH-1:0]        rsp_id,
  output logic                       mul_ce,
  output logic [A_WIDTH-1:0]         mul_din0,
  output logic [B_WIDTH-1:0]         mul_din1,
  input  logic [P_WIDTH-1:0]         mul_dout,
  output logic [31:0]                stall_cnt
);

  logic                stall;
  logic                accept;
  logic                grant_valid;
  logic [ID_WIDTH-1:0] grant_id;
  logic [ID_WIDTH-1:0] rr_ptr_q;
  logic [31:0]         stall_cnt_q;
  logic [A_WIDTH-1:0]  din0_q;
  logic [B_WIDTH-1:0]  din1_q;
  shadow_t             shadow_q [MUL_LATENCY];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req         (req_valid),
    .rr_ptr      (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign rsp_valid = shadow_q[MUL_LATENCY-1].valid;
  assign rsp_id    = ID_WIDTH'(shadow_q[MUL_LATENCY-1].id);
  assign rsp_p     = mul_dout;
  assign stall     = rsp_valid & ~rsp_ready;
  // Multiplier keeps running through reset; stale contents are masked by valids.
  assign mul_ce    = ~ap_rst_n | ~stall;
  assign accept    = ap_rst_n & mul_ce & grant_valid;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  // Operands go straight to the multiplier on accept so it samples them on the
  // same edge that loads shadow stage 0; otherwise the last operands are held.
  assign mul_din0 = accept ? req_a[32'(grant_id)*A_WIDTH +: A_WIDTH] : din0_q;
  assign mul_din1 = accept ? req_b[32'(grant_id)*B_WIDTH +: B_WIDTH] : din1_q;

  always_ff @(posedge ap_clk) begin
    din0_q <= mul_din0;
    din1_q <= mul_din1;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < MUL_LATENCY; i++) shadow_q[i] <= '0;
      rr_ptr_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (mul_ce) begin
        for (int i = MUL_LATENCY - 1; i > 0; i--) shadow_q[i] <= shadow_q[i-1];
        shadow_q[0].valid <= accept;
        shadow_q[0].id    <= accept ? MaxIdWidth'(grant_id) : '0;
      end
      if (accept) begin
        rr_ptr_q <= (32'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + ID_WIDTH'(1);
      end
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_mul_share_scheduler.sv
// Directed and random checks of mul_share_scheduler against a queue-based
// reference model, with a behavioural 3-stage multiplier attached.
module tb_mul_share_scheduler;

  localparam int N  = 4;
  localparam int AW = 14;
  localparam int BW = 28;
  localparam int PW = 32;
  localparam int L  = 3;

  logic            ap_clk = 1'b0;
  logic            ap_rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [PW-1:0]   rsp_p;
  logic [1:0]      rsp_id;
  logic            mul_ce;
  logic [AW-1:0]   mul_din0;
  logic [BW-1:0]   mul_din1;
  logic [PW-1:0]   mul_dout;
  logic [31:0]     stall_cnt;

  always #5 ap_clk = ~ap_clk;

  mul_share_scheduler #(
    .NUM_REQ     (N),
    .A_WIDTH     (AW),
    .B_WIDTH     (BW),
    .P_WIDTH     (PW),
    .MUL_LATENCY (L)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
    .mul_ce    (mul_ce),
    .mul_din0  (mul_din0),
    .mul_din1  (mul_din1),
    .mul_dout  (mul_dout),
    .stall_cnt (stall_cnt)
  );

  // Behavioural multiplier: samples din on a ce edge, result after L ce edges.
  logic signed [31:0] mul_ea, mul_eb;
  logic [31:0]        mp [L];
  assign mul_ea = {18'd0, mul_din0};
  assign mul_eb = {{4{mul_din1[BW-1]}}, mul_din1};
  always_ff @(posedge ap_clk) begin
    if (mul_ce) begin
      mp[0] <= mul_ea * mul_eb;
      for (int i = 1; i < L; i++) mp[i] <= mp[i-1];
    end
  end
  assign mul_dout = mp[L-1];

  // Reference model: ordered queue of accepted ops, each ageing on ce edges.
  typedef struct {
    int          id;
    logic [31:0] p;
    int          ticks;
  } ent_t;

  ent_t        q[$];
  int          rr_m;
  logic [31:0] cnt_m;
  int          tests = 0;
  int          fails = 0;

  logic        last_rsp_valid;
  logic [31:0] last_rsp_p;
  int          last_rsp_id;
  int          last_acc;
  logic        last_ce;
  logic [N-1:0] last_ready;
  logic [31:0] last_stall_cnt;
  int          acc_seen;
  int          rsp_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_prod(input logic [AW-1:0] a, input logic [BW-1:0] b);
    longint pa, pb, pr;
    pa = {50'd0, a};
    pb = {{36{b[BW-1]}}, b};
    pr = pa * pb;
    return pr[31:0];
  endfunction

  // One clock: check outputs mid-cycle, then advance the model across the edge.
  task automatic step();
    bit            m_valid, m_stall, m_ce, found, rdy;
    int            g;
    logic [N-1:0]  exp_ready;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    #1;
    m_valid = (q.size() > 0) && (q[0].ticks == L - 1);
    m_stall = ap_rst_n && m_valid && !rsp_ready;
    m_ce    = !m_stall;
    found   = 0;
    g       = 0;
    for (int off = 0; off < N; off++) begin
      if (!found && req_valid[(rr_m + off) % N]) begin
        found = 1;
        g     = (rr_m + off) % N;
      end
    end
    exp_ready = '0;
    if (found && m_ce && ap_rst_n) exp_ready[g] = 1'b1;

    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("mul_ce", 32'(mul_ce), 32'(m_ce));
    if (ap_rst_n) begin
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid) begin
        chk("rsp_p", rsp_p, q[0].p);
        chk("rsp_id", 32'(rsp_id), q[0].id);
      end
      chk("stall_cnt", stall_cnt, cnt_m);
    end

    last_rsp_valid = rsp_valid;
    last_rsp_p     = rsp_p;
    last_rsp_id    = int'(rsp_id);
    last_ce        = mul_ce;
    last_ready     = req_ready;
    last_stall_cnt = stall_cnt;
    last_acc       = -1;
    for (int i = N - 1; i >= 0; i--) if (req_ready[i]) last_acc = i;
    if (last_acc >= 0) acc_seen++;
    if (ap_rst_n && rsp_valid && rsp_ready) rsp_seen++;
    rdy = rsp_ready;
    a   = req_a[g*AW +: AW];
    b   = req_b[g*BW +: BW];

    @(posedge ap_clk);
    if (!ap_rst_n) begin
      q.delete();
      rr_m  = 0;
      cnt_m = '0;
    end else begin
      if (m_valid && rdy) void'(q.pop_front());
      if (m_ce) begin
        for (int i = 0; i < q.size(); i++) q[i].ticks++;
        if (exp_ready != '0) begin
          q.push_back('{id: g, p: ref_prod(a, b), ticks: 0});
          rr_m = (g + 1) % N;
        end
      end
      if (m_stall && cnt_m != 32'hFFFF_FFFF) cnt_m++;
    end
    @(negedge ap_clk);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
    req_valid[i]       = 1'b1;
    req_a[i*AW +: AW] = a;
    req_b[i*BW +: BW] = b;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    step();
    ap_rst_n = 1'b1;
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (8) step();
  endtask

  task automatic run_single(input int id, input logic [AW-1:0] a, input logic [BW-1:0] b,
                            input logic [31:0] exp_p);
    int  lat;
    bit  seen;
    set_req(id, a, b);
    step();
    chk("single_accept", last_acc, id);
    req_valid = '0;
    lat  = 0;
    seen = 0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      step();
      if (last_rsp_valid) begin
        seen = 1;
        lat  = c;
      end
    end
    chk("single_latency", lat, L);
    chk("single_p", last_rsp_p, exp_p);
    chk("single_id", last_rsp_id, id);
    step();
    chk("single_after", 32'(last_rsp_valid), 0);
  endtask

  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    ap_rst_n  = 1'b0;
    acc_seen  = 0;
    rsp_seen  = 0;
    rr_m      = 0;
    cnt_m     = '0;
    @(negedge ap_clk);

    // Reset state
    step();
    step();
    chk("rst_ready", 32'(last_ready), 0);
    chk("rst_ce", 32'(last_ce), 1);
    ap_rst_n = 1'b1;
    step();
    chk("rst_rsp_valid", 32'(last_rsp_valid), 0);
    chk("rst_stall_cnt", last_stall_cnt, 0);

    // Single op and arithmetic corners
    run_single(2, 14'd3, 28'hFFF_FFFB, 32'hFFFF_FFF1);
    run_single(1, 14'd16383, 28'h800_0000, 32'h0800_0000);
    run_single(0, 14'd0, 28'($urandom), 32'h0);

    // Fairness: all requesters busy, one accept per cycle in rotation
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 14'($urandom), 28'($urandom));
    for (int c = 0; c < 8; c++) begin
      step();
      chk("fair_order", last_acc, c % N);
      if (last_acc >= 0) set_req(last_acc, 14'($urandom), 28'($urandom));
    end
    drain();

    // Sparse traffic and pointer wrap
    do_reset();
    set_req(3, 14'($urandom), 28'($urandom));
    step();
    chk("sparse_g3", last_acc, 3);
    req_valid = '0;
    set_req(1, 14'($urandom), 28'($urandom));
    step();
    chk("sparse_g1", last_acc, 1);
    set_req(1, 14'($urandom), 28'($urandom));
    set_req(2, 14'($urandom), 28'($urandom));
    step();
    chk("sparse_ptr2", last_acc, 2);
    req_valid[2] = 1'b0;
    step();
    chk("sparse_g1b", last_acc, 1);
    drain();

    // Backpressure with a full pipe
    do_reset();
    acc_seen = 0;
    rsp_seen = 0;
    for (int i = 0; i < N; i++) set_req(i, 14'($urandom), 28'($urandom));
    repeat (3) begin
      step();
      if (last_acc >= 0) req_valid[last_acc] = 1'b0;
    end
    rsp_ready = 1'b0;
    step();
    chk("bp_valid", 32'(last_rsp_valid), 1);
    begin
      logic [31:0] p0;
      int          id0;
      p0  = last_rsp_p;
      id0 = last_rsp_id;
      repeat (4) begin
        step();
        chk("bp_ce", 32'(last_ce), 0);
        chk("bp_ready", 32'(last_ready), 0);
        chk("bp_hold_p", last_rsp_p, p0);
        chk("bp_hold_id", last_rsp_id, id0);
      end
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_stall_cnt", last_stall_cnt, 5);
    if (last_acc >= 0) req_valid[last_acc] = 1'b0;
    drain();
    chk("bp_no_loss", rsp_seen, acc_seen);

    // Reset with operations in flight
    for (int i = 0; i < 3; i++) set_req(i, 14'($urandom), 28'($urandom));
    repeat (3) begin
      step();
      if (last_acc >= 0) req_valid[last_acc] = 1'b0;
    end
    do_reset();
    repeat (5) begin
      step();
      chk("rst_fl_no_rsp", 32'(last_rsp_valid), 0);
    end
    chk("rst_fl_stall_cnt", last_stall_cnt, 0);
    for (int i = 0; i < N; i++) set_req(i, 14'($urandom), 28'($urandom));
    step();
    chk("rst_fl_rr", last_acc, 0);
    drain();

    // Random traffic with random backpressure and cancellations
    acc_seen = 0;
    rsp_seen = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) set_req(i, 14'($urandom), 28'($urandom));
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
      if (last_acc >= 0) req_valid[last_acc] = 1'b0;
    end
    drain();
    chk("rand_no_loss", rsp_seen, acc_seen);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_share_scheduler.md
Name: mul_share_scheduler

Overview:
- Shares one pipelined 14-bit unsigned × 28-bit signed → 32-bit multiplier between NUM_REQ requesters inside the read_C stage of the Sextans SpMM datapath.
- Arbitrates round-robin among requesters and drives the multiplier's din0, din1 and ce.
- Tracks each operation's valid bit and requester id in a shadow pipeline aligned to the multiplier.
- Returns each product with its requester id on one valid/ready response port, stalling the whole pipeline on backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- A_WIDTH, 14, unsigned operand width.
- B_WIDTH, 28, signed operand width.
- P_WIDTH, 32, product width (multiplier truncates).
- MUL_LATENCY, 3, ce-enabled clock edges from mul_din sample to matching mul_dout.
- ID_WIDTH, clog2(NUM_REQ), requester id width.

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  reset: one clock; synchronous, active-low
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_a  in  NUM_REQ*A_WIDTH  packed unsigned operands, requester i at slice i
- req_b  in  NUM_REQ*B_WIDTH  packed signed operands
- rsp_valid  out  1  product valid
- rsp_ready  in  1  consumer accept
- rsp_p  out  P_WIDTH  product
- rsp_id  out  ID_WIDTH  originating requester
- mul_ce  out  1  multiplier clock enable
- mul_din0  out  A_WIDTH  to multiplier din0
- mul_din1  out  B_WIDTH  to multiplier din1
- mul_dout  in  P_WIDTH  from multiplier dout
- stall_cnt  out  32  saturating count of backpressure cycles

Behaviour:
- Reset values: rsp_valid=0, all shadow valids=0, shadow ids=0, rr_ptr=0, stall_cnt=0. Outputs during reset: req_ready=0, mul_ce=1.
- Stall: stall = rsp_valid & ~rsp_ready. mul_ce = ~stall, combinational.
- Shadow pipeline: MUL_LATENCY stages of {valid, id}. Each stage advances only when mul_ce=1, in lockstep with the multiplier.
- Response: rsp_valid is the last shadow valid. rsp_id is the last shadow id. rsp_p = mul_dout, passed through unregistered.
- Arbitration:
  - Grant goes to the first asserted req_valid at or after rr_ptr, searching upward with wrap-around.
  - req_ready[g] = grant & mul_ce. A request is accepted when req_valid[g] & req_ready[g].
  - On accept: mul_din0/mul_din1 take the slices of requester g, shadow stage 0 loads {1, g}, and rr_ptr becomes (g+1) mod NUM_REQ.
  - With no accept and mul_ce=1, stage 0 loads valid=0. mul_din holds its last value (don't-care).
  - rr_ptr is unchanged when there is no accept.
- Throughput: one accept per cycle while not stalled. A request accepted at edge t produces rsp_valid in cycle t+MUL_LATENCY if no stall occurs.
- Stall with a bubble in the pipe: the whole pipe still freezes. There is no bubble collapse, so the multiplier ce and the shadow pipe stay aligned.
- Ordering: responses leave in accept order. No reordering, no drops.
- Requester rules:
  - A requester must hold req_valid and its operands stable until accepted.
  - Deasserting before accept is legal and cancels the request.
- Arithmetic: product = zero-extend(a) × signed(b), truncated by the multiplier to its low P_WIDTH bits. This block performs no arithmetic.
- stall_cnt increments each stall cycle and saturates at 0xFFFFFFFF.
- Reset mid-operation: all in-flight products are discarded (shadow valids cleared) and rr_ptr returns to 0. Stale multiplier register contents are masked by the cleared valids.
- Simultaneous events: a stall cycle with pending requests grants nothing and leaves rr_ptr unchanged. A cycle with a response accepted and a new request accepted is legal at full rate.

Decomposition:
- Shared package mul_share_pkg:
  - function clog2
  - default width constants A_WIDTH=14, B_WIDTH=28, P_WIDTH=32
  - MUL_LATENCY default
  - typedef of the shadow entry {valid, id}
- One sub-module: rr_arbiter (NUM_REQ). Inputs: req vector, rr_ptr. Outputs: grant_valid, grant_id (combinational). rr_ptr stays in the parent.
- The multiplier is instantiated beside this block by the parent, not inside it.

Test Plan:
- Single op: req 2 with a=3, b=-5, rsp_ready=1 → exactly 3 cycles after accept: rsp_valid=1, rsp_p=0xFFFFFFF1, rsp_id=2, then rsp_valid=0.
- Fairness: all 4 req_valid held high for 8 cycles → accept order 0,1,2,3,0,1,2,3, one per cycle; responses follow in the same order 3 cycles later.
- Backpressure: pipe full, rsp_ready low for 5 cycles → mul_ce=0, req_ready=0, rsp_p/rsp_id held stable, stall_cnt=5; after release all results arrive in order with none lost.
- Truncation corner: a=16383, b=-134217728 → rsp_p=0x08000000. Also a=0, b=any → 0.
- Sparse traffic: only req 3 valid, then req 1 valid the next cycle → grants 3 then 1, and rr_ptr wraps 3→0→2.
- Reset mid-flight: assert ap_rst_n=0 for 1 cycle with 3 ops in flight → no rsp_valid afterwards, stall_cnt=0, and the next grant starts the search from requester 0.
